// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32I pipeline control slice.
package rv32i_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    FLUSH    = 2'd2,
    IO_WAIT  = 2'd3
  } pctrl_state_t;

  localparam int unsigned REG_W = 5;

  localparam logic [31:0] NOP_IW_DEFAULT = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

endpackage

// File: rtl/rv32i_hazard_detect.sv
// Load-use comparator: flags an ID operand that needs the result of a load still in EX.
module rv32i_hazard_detect
  import rv32i_pkg::*;
(
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             ex_wb_en,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_wb_reg,
  output logic             hazard
);

  logic ex_load_wr;
  logic rs1_hit;
  logic rs2_hit;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign ex_load_wr = ex_is_load & ex_wb_en & (ex_wb_reg != '0);
  assign rs1_hit    = id_rs1_used & (id_rs1 == ex_wb_reg);
  assign rs2_hit    = id_rs2_used & (id_rs2 == ex_wb_reg);
  assign hazard     = ex_load_wr & (rs1_hit | rs2_hit);

endmodule

// File: rtl/rv32i_pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: load-use, taken branch and IO waits.
module rv32i_pipe_ctrl
  import rv32i_pkg::*;
#(
  parameter int unsigned IO_TIMEOUT = 16,
  parameter logic [31:0] NOP_IW     = NOP_IW_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             ex_wb_en,
  input  logic [REG_W-1:0] ex_wb_reg,
  input  logic             ex_is_load,
  input  logic             ex_br_taken,
  input  logic [31:0]      ex_br_target,
  input  logic             mem_io_en,
  input  logic             io_ack,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic             pc_load,
  output logic [31:0]      pc_target,
  output logic             io_timeout,
  output pctrl_state_t     dbg_state
);

  localparam int unsigned     CW       = $clog2(IO_TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(IO_TIMEOUT - 1);

  if (IO_TIMEOUT < 1) begin : g_bad_timeout
    $error("IO_TIMEOUT must be at least 1");
  end
  if (NOP_IW[6:0] != OPC_OP_IMM) begin : g_bad_nop
    $error("NOP_IW must be an OP-IMM encoding");
  end

  pctrl_state_t  state;
  pctrl_state_t  state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          hazard;
  logic          io_expired;

  rv32i_hazard_detect u_hazard (
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_wb_en    (ex_wb_en),
    .ex_is_load  (ex_is_load),
    .ex_wb_reg   (ex_wb_reg),
    .hazard      (hazard)
  );

  // IO handshake: mem_io_en is the request and stays asserted while MEM is frozen;
  // io_ack completes it in the cycle it is high, with no stall in that cycle.
  assign io_expired = (state == IO_WAIT) & ~io_ack & (wait_cnt == CNT_LAST);

  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    pc_load   = 1'b0;
    pc_target = '0;
    state_nxt = state;
    unique case (state)
      RUN: begin
        if (mem_io_en & ~io_ack) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          stall_ex  = 1'b1;
          stall_mem = 1'b1;
          state_nxt = IO_WAIT;
        end else if (ex_br_taken) begin
          pc_load   = 1'b1;
          pc_target = ex_br_target;
          flush_id  = 1'b1;
          bubble_ex = 1'b1;
          state_nxt = FLUSH;
        end else if (hazard) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bubble_ex = 1'b1;
          state_nxt = LD_STALL;
        end
      end
      LD_STALL: state_nxt = RUN;
      FLUSH:    state_nxt = RUN;
      IO_WAIT: begin
        if (io_ack | io_expired) begin
          state_nxt = RUN;
        end else begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          stall_ex  = 1'b1;
          stall_mem = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
    if (!reset) begin
      stall_if  = 1'b0;
      stall_id  = 1'b0;
      stall_ex  = 1'b0;
      stall_mem = 1'b0;
      bubble_ex = 1'b0;
      flush_id  = 1'b0;
      pc_load   = 1'b0;
      pc_target = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      wait_cnt   <= '0;
      io_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == IO_WAIT) && (state_nxt == IO_WAIT)) begin
        wait_cnt <= wait_cnt + CW'(1);
      end else begin
        wait_cnt <= '0;
      end
      if (io_expired) begin
        io_timeout <= 1'b1;
      end
    end
  end

  assign dbg_state = state;

endmodule
